key_sequence_driver: RTL

- Transmit end of the serial key interface used by our key-locked FSM benchmarks.
- Holds a KEY_W-bit unlock key and shifts it out LSB-first on a 1-bit key line.
- Waits for an unlock acknowledge from the locked FSM, retries on timeout, and after MAX_TRIES failed attempts enters a sticky lockout that only reset clears.
- Drives key_o on posedge clk, so the line is stable at the consumer's negedge sampling point.

---
 rtl/key_sequence_driver.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/key_sequence_driver.sv
// key_sequence_driver
// Transmit end of the serial key interface. Holds a KEY_W-bit unlock key,
// shifts it out LSB-first on key_o, waits for unlock_ok, retries after a
// timeout and enters a sticky lockout after MAX_TRIES failed attempts.
//
// Optional build macro: KEY_DRV_PARITY_EN
//   defined   -> each attempt appends one even-parity bit after the key bits
//   undefined -> each attempt emits exactly KEY_W key bits
//
// Timing: a start sampled at edge t is held for one cycle in a pending
// flag, so SHIFT (and the first key bit on key_o) begins after edge t+1.
// All outputs are registered from the next-state values so they line up
// with the internal state cycle by cycle.
module key_sequence_driver #(
    parameter int KEY_W     = 8,
    parameter int MAX_TRIES = 5,
    parameter int TIMEOUT   = 4,
    parameter int GAP       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_we,
    input  logic [KEY_W-1:0]               key_in,
    input  logic                           start,
    input  logic                           unlock_ok,
    output logic                           key_o,
    output logic                           key_vld,
    output logic                           busy,
    output logic                           done,
    output logic                           locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] try_cnt
);

`ifdef KEY_DRV_PARITY_EN
    localparam int SHIFT_LEN = KEY_W + 1;
`else
    localparam int SHIFT_LEN = KEY_W;
`endif

    localparam int IW   = $clog2(SHIFT_LEN);
    localparam int TW   = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int TMW  = $clog2(TMAX + 1);

    localparam logic [IW-1:0]  IDX_LAST = IW'(SHIFT_LEN - 1);
    localparam logic [TW-1:0]  TRY_MAX  = TW'(MAX_TRIES);
    localparam logic [TMW-1:0] T_WAIT   = TMW'(TIMEOUT);
    localparam logic [TMW-1:0] T_GAP    = TMW'(GAP);
    localparam logic [TMW-1:0] T_ONE    = TMW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    // Even parity over the whole key (XOR of all bits).
    function automatic logic even_parity(input logic [KEY_W-1:0] k);
        return ^k;
    endfunction

    // Serial bit for position idx: key bits first, then the optional parity bit.
    function automatic logic select_bit(input logic [KEY_W-1:0] k,
                                        input logic [IW-1:0]    idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
            b = (idx == IW'(i)) ? k[i] : b;
        end
`ifdef KEY_DRV_PARITY_EN
        b = (idx == IW'(KEY_W)) ? even_parity(k) : b;
`endif
        return b;
    endfunction

    state_t             state_r, state_nx_s;
    logic [KEY_W-1:0]   key_r;
    logic               key_loaded_r;
    logic               start_q_r, start_q_nx_s;
    logic [IW-1:0]      idx_r, idx_nx_s;
    logic [TMW-1:0]     timer_r, timer_nx_s;
    logic [TW-1:0]      try_r, try_nx_s, try_inc_s;
    logic               key_load_s;
    logic               idle_like_s;

    logic               key_o_r, key_vld_r, busy_r, done_r, locked_r;
    logic               key_o_nx_s, key_vld_nx_s, busy_nx_s, done_nx_s, locked_nx_s;

    // Key-load and start-acceptance qualification.
    always_comb begin
        idle_like_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
        key_load_s   = key_we && !start_q_r &&
                       (idle_like_s || (state_r == ST_LOCKOUT));
        start_q_nx_s = start && key_loaded_r && !key_we && !start_q_r && idle_like_s;
        try_inc_s    = (try_r == TRY_MAX) ? try_r : (try_r + TW'(1));
    end

    // Next-state, bit index, timer and attempt counter.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        timer_nx_s = timer_r;
        try_nx_s   = try_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_q_r) begin
                    state_nx_s = ST_SHIFT;
                    idx_nx_s   = {IW{1'b0}};
                    try_nx_s   = {TW{1'b0}};
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_SHIFT: begin
                if (idx_r == IDX_LAST) begin
                    state_nx_s = ST_WAIT;
                    idx_nx_s   = {IW{1'b0}};
                    timer_nx_s = T_WAIT;
                end else begin
                    idx_nx_s   = idx_r + IW'(1);
                end
            end
            ST_WAIT: begin
                if (unlock_ok) begin
                    state_nx_s = ST_DONE;
                end else if (timer_r <= T_ONE) begin
                    try_nx_s = try_inc_s;
                    if (try_inc_s == TRY_MAX) begin
                        state_nx_s = ST_LOCKOUT;
                    end else begin
                        state_nx_s = ST_GAP;
                        timer_nx_s = T_GAP;
                    end
                end else begin
                    timer_nx_s = timer_r - T_ONE;
                end
            end
            ST_GAP: begin
                if (timer_r <= T_ONE) begin
                    state_nx_s = ST_SHIFT;
                    idx_nx_s   = {IW{1'b0}};
                end else begin
                    timer_nx_s = timer_r - T_ONE;
                end
            end
            ST_LOCKOUT: begin
                state_nx_s = ST_LOCKOUT;
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = {IW{1'b0}};
                timer_nx_s = {TMW{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        key_vld_nx_s = 1'b0;
        key_o_nx_s   = 1'b0;
        busy_nx_s    = 1'b0;
        done_nx_s    = 1'b0;
        locked_nx_s  = 1'b0;
        case (state_nx_s)
            ST_SHIFT: begin
                key_vld_nx_s = 1'b1;
                key_o_nx_s   = select_bit(key_r, idx_nx_s);
                busy_nx_s    = 1'b1;
            end
            ST_WAIT, ST_GAP: begin
                busy_nx_s = 1'b1;
            end
            ST_DONE: begin
                done_nx_s = 1'b1;
            end
            ST_LOCKOUT: begin
                locked_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            start_q_r <= 1'b0;
            idx_r     <= {IW{1'b0}};
            timer_r   <= {TMW{1'b0}};
            try_r     <= {TW{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            start_q_r <= start_q_nx_s;
            idx_r     <= idx_nx_s;
            timer_r   <= timer_nx_s;
            try_r     <= try_nx_s;
        end
    end

    // Key register; writes only accepted while no sequence is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r        <= {KEY_W{1'b0}};
            key_loaded_r <= 1'b0;
        end else if (key_load_s) begin
            key_r        <= key_in;
            key_loaded_r <= 1'b1;
        end else begin
            key_r        <= key_r;
            key_loaded_r <= key_loaded_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_o_r   <= 1'b0;
            key_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            key_o_r   <= key_o_nx_s;
            key_vld_r <= key_vld_nx_s;
            busy_r    <= busy_nx_s;
            done_r    <= done_nx_s;
            locked_r  <= locked_nx_s;
        end
    end

    assign key_o      = key_o_r;
    assign key_vld    = key_vld_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign locked_out = locked_r;
    assign try_cnt    = try_r;

endmodule
